// File: rtl/adc_sample_ctrl.sv
// adc_sample_ctrl
// Sequencer between the 10-bit ADC output and the DAC-side consumer.
// The block paces conversions with a programmable sample-rate divider.
// It averages 2^AVG_LOG2 consecutive ADC codes into each result.
// Each averaged code is handed downstream over a valid/ready handshake.
// Results dropped while the consumer stalls set a sticky overrun flag.
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   rst           synchronous reset, active-high, highest priority
//   enable        level; 1 = run sampling, 0 = stop and return to IDLE
//   sample_div    clocks per sample, latched on leaving IDLE (0 acts as 1)
//   adc_din       ADC code, sampled only on capture edges
//   ovr_clr       one-cycle pulse clearing overrun
//   out_data      averaged code
//   out_valid     out_data is valid
//   out_ready     consumer accepts when out_valid && out_ready at an edge
//   sample_strobe one-cycle pulse on each capture edge
//   busy          1 while the sequencer is in RUN
//   overrun       sticky; a result was dropped
module adc_sample_ctrl #(
  parameter int DATA_W   = 10,
  parameter int DIV_W    = 16,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DIV_W-1:0]  sample_div,
  input  logic [DATA_W-1:0] adc_din,
  input  logic              ovr_clr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sample_strobe,
  output logic              busy,
  output logic              overrun
);

  // The accumulator is wide enough for 2^AVG_LOG2 full-scale codes.
  // The sample counter keeps at least one bit so AVG_LOG2=0 still elaborates.
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [CNT_W-1:0] LAST_N = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_next;
  logic [DIV_W-1:0]  tick, tick_next;
  logic [DIV_W-1:0]  div_reg, div_next;
  logic [ACC_W-1:0]  acc, acc_next;
  logic [CNT_W-1:0]  n, n_next;
  logic [DATA_W-1:0] out_data_next;
  logic              out_valid_next;
  logic              strobe_next;
  logic              overrun_next;

  logic              accept;
  logic              drop;
  logic [ACC_W-1:0]  sum;

  // State register. Reset clears every register so that no strobe or result
  // can appear until enable is sampled again from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tick          <= '0;
      div_reg       <= '0;
      acc           <= '0;
      n             <= '0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      sample_strobe <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state         <= state_next;
      tick          <= tick_next;
      div_reg       <= div_next;
      acc           <= acc_next;
      n             <= n_next;
      out_data      <= out_data_next;
      out_valid     <= out_valid_next;
      sample_strobe <= strobe_next;
      overrun       <= overrun_next;
    end
  end

  // Next-state logic. An accept retires the held result unless a new result
  // is loaded on the same edge. A result that arrives while the previous one
  // is still unaccepted is dropped, and out_data keeps the older value.
  always_comb begin
    state_next     = state;
    tick_next      = tick;
    div_next       = div_reg;
    acc_next       = acc;
    n_next         = n;
    out_data_next  = out_data;
    out_valid_next = out_valid;
    strobe_next    = 1'b0;
    drop           = 1'b0;
    accept         = out_valid && out_ready;
    sum            = acc + ACC_W'(adc_din);

    if (accept) begin
      out_valid_next = 1'b0;
    end

    case (state)
      IDLE: begin
        if (enable) begin
          div_next   = (sample_div == '0) ? DIV_W'(1) : sample_div;
          tick_next  = '0;
          acc_next   = '0;
          n_next     = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        // Disabling takes effect even on a capture edge; the partial
        // average is thrown away rather than emitted short.
        if (!enable) begin
          state_next = IDLE;
          tick_next  = '0;
          acc_next   = '0;
          n_next     = '0;
        end else if (tick == div_reg - DIV_W'(1)) begin
          tick_next   = '0;
          strobe_next = 1'b1;
          if (n == LAST_N) begin
            acc_next = '0;
            n_next   = '0;
            if (!out_valid || accept) begin
              out_data_next  = DATA_W'(sum >> AVG_LOG2);
              out_valid_next = 1'b1;
            end else begin
              drop = 1'b1;
            end
          end else begin
            acc_next = sum;
            n_next   = n + CNT_W'(1);
          end
        end else begin
          tick_next = tick + DIV_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A drop on the same edge as a clear wins, so the loss is not hidden.
    if (drop) begin
      overrun_next = 1'b1;
    end else if (ovr_clr) begin
      overrun_next = 1'b0;
    end else begin
      overrun_next = overrun;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// tb_adc_sample_ctrl
// Directed testbench for adc_sample_ctrl with hand-computed expectations.
// Two instances share every input:
//   dut2 averages four samples (AVG_LOG2=2).
//   dut0 passes each capture straight through (AVG_LOG2=0).
// Inputs change 1 ns after each rising edge. Outputs are checked at the same
// point, so every check sees the result of the edge just taken.
module tb_adc_sample_ctrl;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] sample_div;
  logic [9:0]  adc_din;
  logic        ovr_clr;
  logic        out_ready;

  logic [9:0]  out_data2;
  logic        out_valid2, strobe2, busy2, overrun2;
  logic [9:0]  out_data0;
  logic        out_valid0, strobe0, busy0, overrun0;

  int vectors;
  int miscompares;

  adc_sample_ctrl #(.DATA_W(10), .DIV_W(16), .AVG_LOG2(2)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .sample_div(sample_div),
    .adc_din(adc_din), .ovr_clr(ovr_clr), .out_data(out_data2),
    .out_valid(out_valid2), .out_ready(out_ready), .sample_strobe(strobe2),
    .busy(busy2), .overrun(overrun2)
  );

  adc_sample_ctrl #(.DATA_W(10), .DIV_W(16), .AVG_LOG2(0)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .sample_div(sample_div),
    .adc_din(adc_din), .ovr_clr(ovr_clr), .out_data(out_data0),
    .out_valid(out_valid0), .out_ready(out_ready), .sample_strobe(strobe0),
    .busy(busy0), .overrun(overrun0)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and count it.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, take one rising edge, then settle 1 ns.
  task automatic applyStimulus(input logic en, input logic [9:0] din,
                               input logic rdy, input logic clr);
    enable    = en;
    adc_din   = din;
    out_ready = rdy;
    ovr_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  // Hold rst high for a number of edges with all other inputs idle.
  task automatic resetAll(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 10'd0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  logic [9:0] avg_vals [4];
  logic [9:0] re_vals  [4];

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    enable      = 1'b0;
    sample_div  = 16'd0;
    adc_din     = 10'd0;
    ovr_clr     = 1'b0;
    out_ready   = 1'b0;
    avg_vals    = '{10'd100, 10'd200, 10'd300, 10'd404};
    re_vals     = '{10'd10, 10'd20, 10'd30, 10'd41};

    // Reset state.
    resetAll(2);
    checkOutput("rst_data",    out_data2,  0);
    checkOutput("rst_valid",   out_valid2, 0);
    checkOutput("rst_strobe",  strobe2,    0);
    checkOutput("rst_busy",    busy2,      0);
    checkOutput("rst_overrun", overrun2,   0);

    // Basic averaging: div 4, captures at edges 4, 8, 12, 16.
    // (100+200+300+404)/4 = 251. The live sample_div change must be ignored.
    sample_div = 16'd4;
    applyStimulus(1'b1, 10'd0, 1'b0, 1'b0);
    checkOutput("avg_busy", busy2, 1);
    checkOutput("avg_strobe_e0", strobe2, 0);
    sample_div = 16'd7;
    for (int e = 1; e <= 16; e++) begin
      applyStimulus(1'b1, avg_vals[(e - 1) / 4], 1'b0, 1'b0);
      checkOutput($sformatf("avg_strobe_e%0d", e), strobe2, ((e % 4) == 0) ? 1 : 0);
      if (e == 15) checkOutput("avg_valid_e15", out_valid2, 0);
    end
    checkOutput("avg_valid", out_valid2, 1);
    checkOutput("avg_data",  out_data2,  251);

    // Disable after two more captures (edges 20, 24).
    // The pending 251 must survive the disable.
    for (int e = 17; e <= 24; e++) applyStimulus(1'b1, 10'd500, 1'b0, 1'b0);
    checkOutput("dis_strobe_e24", strobe2, 1);
    applyStimulus(1'b0, 10'd500, 1'b0, 1'b0);
    checkOutput("dis_busy",   busy2,      0);
    checkOutput("dis_strobe", strobe2,    0);
    checkOutput("dis_valid",  out_valid2, 1);
    checkOutput("dis_data",   out_data2,  251);
    applyStimulus(1'b0, 10'd0, 1'b1, 1'b0);
    checkOutput("dis_accept_valid", out_valid2, 0);

    // Re-enable with div 2: a fresh average (10+20+30+41)/4 = 25.
    sample_div = 16'd2;
    applyStimulus(1'b1, 10'd0, 1'b1, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      applyStimulus(1'b1, re_vals[(e - 1) / 2], 1'b1, 1'b0);
      checkOutput($sformatf("re_strobe_e%0d", e), strobe2, ((e % 2) == 0) ? 1 : 0);
    end
    checkOutput("re_valid", out_valid2, 1);
    checkOutput("re_data",  out_data2,  25);

    // Divider 0 and AVG 0: a result on every edge with a ramp input.
    resetAll(1);
    sample_div = 16'd0;
    applyStimulus(1'b1, 10'd0, 1'b1, 1'b0);
    checkOutput("ramp_busy", busy0, 1);
    for (int i = 0; i < 1024; i++) begin
      applyStimulus(1'b1, 10'(i), 1'b1, 1'b0);
      checkOutput($sformatf("ramp_strobe_%0d", i), strobe0,    1);
      checkOutput($sformatf("ramp_valid_%0d", i),  out_valid0, 1);
      checkOutput($sformatf("ramp_data_%0d", i),   out_data0,  i);
      checkOutput($sformatf("ramp_ovr_%0d", i),    overrun0,   0);
    end

    // Stall and overrun on dut0 with div 3. First retire the pending result.
    applyStimulus(1'b0, 10'd0, 1'b1, 1'b0);
    checkOutput("stall_idle_valid", out_valid0, 0);
    sample_div = 16'd3;
    applyStimulus(1'b1, 10'd55, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'd55, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'd55, 1'b0, 1'b0);
    checkOutput("stall_valid_e2", out_valid0, 0);
    applyStimulus(1'b1, 10'd55, 1'b0, 1'b0);
    checkOutput("stall_strobe_e3", strobe0,    1);
    checkOutput("stall_valid_e3",  out_valid0, 1);
    checkOutput("stall_data_e3",   out_data0,  55);
    applyStimulus(1'b1, 10'd77, 1'b0, 1'b0);
    checkOutput("stall_data_e4", out_data0, 55);
    applyStimulus(1'b1, 10'd77, 1'b0, 1'b0);
    checkOutput("stall_valid_e5", out_valid0, 1);
    applyStimulus(1'b1, 10'd77, 1'b0, 1'b0);
    checkOutput("drop_overrun", overrun0,  1);
    checkOutput("drop_data",    out_data0, 55);
    applyStimulus(1'b1, 10'd77, 1'b0, 1'b1);
    checkOutput("clr_overrun", overrun0, 0);
    applyStimulus(1'b1, 10'd77, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'd77, 1'b0, 1'b1);
    checkOutput("clr_drop_overrun", overrun0,  1);
    checkOutput("clr_drop_data",    out_data0, 55);
    applyStimulus(1'b1, 10'd77, 1'b0, 1'b1);
    checkOutput("clr2_overrun", overrun0, 0);
    applyStimulus(1'b1, 10'd77, 1'b0, 1'b0);

    // Accept on a result edge: new value loads, out_valid stays 1, no drop.
    applyStimulus(1'b1, 10'd88, 1'b1, 1'b0);
    checkOutput("acc_new_data",    out_data0,  88);
    checkOutput("acc_new_valid",   out_valid0, 1);
    checkOutput("acc_new_overrun", overrun0,   0);
    applyStimulus(1'b1, 10'd99, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'd99, 1'b0, 1'b0);
    applyStimulus(1'b1, 10'd99, 1'b0, 1'b0);
    checkOutput("pre_rst_overrun", overrun0,  1);
    checkOutput("pre_rst_data",    out_data0, 88);

    // Reset mid-RUN with out_valid=1 and overrun=1.
    resetAll(1);
    checkOutput("midrst_data",    out_data0,  0);
    checkOutput("midrst_valid",   out_valid0, 0);
    checkOutput("midrst_strobe",  strobe0,    0);
    checkOutput("midrst_busy",    busy0,      0);
    checkOutput("midrst_overrun", overrun0,   0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 10'd5, 1'b0, 1'b0);
      checkOutput($sformatf("postrst_strobe_%0d", i), strobe0, 0);
      checkOutput($sformatf("postrst_busy_%0d", i),   busy0,   0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
